div_iter: RTL and testbench
===========================

# div_iter

Parametrised iterative signed/unsigned divider: the multi-cycle divide unit driven by the EX stage for DIV/DIVU. It generalises the fixed 32-bit, one-bit-per-cycle divider in three ways: configurable operand width, configurable quotient bits retired per cycle, and an explicit divide-by-zero flag. EX holds its pipeline stall while `ready_o` is low, then reads `{remainder, quotient}` into HI/LO.

## Interface
- `WIDTH`, default 32: operand width. Must be even and ≥ 8.
- `UNROLL`, default 1: quotient bits produced per cycle. Legal values are 1, 2 and 4, and it must divide `WIDTH`.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-low (asserted at 0).
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled at start.
- `opdata1_i`  in  WIDTH  dividend. Sampled at start.
- `opdata2_i`  in  WIDTH  divisor. Sampled at start.
- `start_i`  in  1  request. Held high by EX until it sees `ready_o`.
- `annul_i`  in  1  cancel, caused by a flush or exception. Overrides `start_i`.
- `result_o`  out  2*WIDTH  `{remainder, quotient}`, registered.
- `ready_o`  out  1  result valid, registered.
- `divzero_o`  out  1  current result is from a zero divisor, registered.

## Operation
- Four states:
  - FREE: idle.
  - BYZERO: zero-divisor shortcut.
  - ON: iterating.
  - END: result held.
- FREE:
  - If `start_i=1` and `annul_i=0`, latch the operands and `signed_div_i`.
  - Divisor == 0 → BYZERO.
  - Otherwise → ON with `cnt=0`.
- Signed mode:
  - Latch the absolute values of the operands.
  - Record `qneg = sign1 ^ sign2` and `rneg = sign1`.
- ON:
  - Each cycle performs `UNROLL` restoring steps on `{rem, dividend}` (width 2*WIDTH+1), shifting quotient bits in at the LSB.
  - `cnt += UNROLL`.
  - When `cnt` reaches `WIDTH - UNROLL`, the final step goes to END.
- Entering END from ON:
  - Quotient is negated if `qneg`; remainder is negated if `rneg`.
  - `result_o` is loaded, `ready_o=1`, `divzero_o=0`.
- BYZERO → END the next cycle, with `result_o=0` and `divzero_o=1`.
- END:
  - `ready_o` and `result_o` hold while `start_i=1`.
  - `start_i=0` → FREE, with `ready_o=0` and `result_o` cleared to 0 on the same edge.
- `annul_i=1` in any state → FREE on the next edge. `ready_o`, `divzero_o` and `result_o` clear to 0. An annul in FREE has no effect.
- Overflow case (most-negative ÷ −1, signed): quotient = most-negative (wraps), remainder = 0. No flag.
- Unsigned mode never negates.
- Operand changes after the start cycle are ignored.

## Timing
- Reset (`rst=0`, asynchronous):
  - State = FREE, `cnt=0`.
  - `result_o=0`, `ready_o=0`, `divzero_o=0`.
- Let the start be accepted at edge k, and N = WIDTH/UNROLL.
  - Normal divide: `ready_o` rises after edge k+N. Defaults give 32 cycles; `UNROLL=4` gives 8.
  - Zero divisor: `ready_o` rises after edge k+2.
- EX deasserts `start_i` in the cycle `ready_o` is seen. The unit is in FREE after the following edge and can accept a new start one cycle after that.
- Back-to-back with `start_i` held high: no new operation begins until `start_i` has been low for one edge.
- `annul_i` and `start_i` high together in FREE: nothing starts.
- Reset asserted mid-operation: immediate return to the reset values. No partial result is visible.

## Structure
- Add to `defines.v`:
  - State encodings: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
  - Existing names reused: `DivResultReady`, `DivResultNotReady`, `DivStart`, `DivStop`.
- One sub-module, `div_step`:
  - Combinational, parametrised by `WIDTH`.
  - Performs one restoring subtract-and-shift on `{rem, dividend}` and produces the next partial value.
  - Instantiated `UNROLL` times in a chain inside `div_iter`.

## Test plan
- Unsigned, WIDTH=32, UNROLL=1:
  - Stimulus: 100 ÷ 7.
  - Required: `result_o = {32'd2, 32'd14}`, `ready_o` exactly 32 cycles after the start edge, `divzero_o=0`.
- Signed, same configuration:
  - Stimulus: 0xFFFFFFF9 (−7) ÷ 2.
  - Required: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed overflow:
  - Stimulus: 0x80000000 ÷ 0xFFFFFFFF.
  - Required: quotient 0x80000000, remainder 0.
- Zero divisor:
  - Stimulus: 5 ÷ 0 (either mode).
  - Required: `ready_o` 2 cycles after start, `result_o=0`, `divzero_o=1`.
  - Then drop `start_i`: `ready_o=0` and the unit is back in FREE.
- Annul mid-operation:
  - Stimulus: `annul_i` pulsed in cycle 10 of 100 ÷ 7.
  - Required: FREE next edge, `ready_o` never rises, and a fresh 9 ÷ 3 started afterwards returns {0, 3}.
- UNROLL=4, WIDTH=32:
  - Stimulus: 0xFFFFFFFF ÷ 0x10 unsigned.
  - Required: quotient 0x0FFFFFFF, remainder 0xF, `ready_o` after 8 cycles.
  - Also hold `start_i` high 5 extra cycles: result stable throughout, no restart.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative divider.
// State encodings plus the EX-side handshake level names.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_iter_if.sv
// EX <-> divider handshake bundle. EX drives through master,
// the divider consumes through slave.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               divzero_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, divzero_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, divzero_o
    );
endinterface

// File: rtl/div_iter_step.sv
// One restoring subtract-and-shift step. part = {cand[WIDTH:0], low[WIDTH-1:0]};
// cand is the shifted partial remainder, low holds the pending dividend and quotient bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  part_i,
    input  logic [WIDTH-1:0]  divisor_i,
    output logic [2*WIDTH:0]  part_o
);
    logic [WIDTH:0]   cand;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] low;
    logic             ge;
    logic [WIDTH-1:0] new_rem;

    assign cand    = part_i[2*WIDTH:WIDTH];
    assign low     = part_i[WIDTH-1:0];
    assign diff    = cand - {1'b0, divisor_i};
    assign ge      = (cand >= {1'b0, divisor_i});
    // cand < 2*divisor, so a successful subtract always fits in WIDTH bits.
    assign new_rem = ge ? diff[WIDTH-1:0] : cand[WIDTH-1:0];
    assign part_o  = {new_rem, low, ge};

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider retiring UNROLL quotient bits per cycle.
// Result is {remainder, quotient}; sign fix-up is applied on entry to END.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input logic      clk,
    input logic      rst,
    div_iter_if.slave bus
);
    localparam int PW = 2*WIDTH + 1;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - UNROLL);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      part_q;
    logic [WIDTH-1:0]   divisor_q;
    logic               qneg_q;
    logic               rneg_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
    logic               divzero_q;

    logic [UNROLL:0][PW-1:0] chain;
    logic [PW-1:0]      part_d;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;

    assign chain[0] = part_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .part_i    (chain[g]),
            .divisor_i (divisor_q),
            .part_o    (chain[g+1])
        );
    end

    assign part_d = chain[UNROLL];
    assign sign1  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign sign2  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign abs1   = cond_neg(bus.opdata1_i, sign1);
    assign abs2   = cond_neg(bus.opdata2_i, sign2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            part_q    <= '0;
            divisor_q <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
            divzero_q <= 1'b0;
        end else if (bus.annul_i) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
            divzero_q <= 1'b0;
        end else begin
            case (state_q)
                DivFree: begin
                    if (bus.start_i == DivStart) begin
                        part_q    <= {{WIDTH{1'b0}}, abs1, 1'b0};
                        divisor_q <= abs2;
                        qneg_q    <= sign1 ^ sign2;
                        rneg_q    <= sign1;
                        cnt_q     <= '0;
                        state_q   <= (bus.opdata2_i == '0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    // Two edges in this state keep the zero-divisor latency fixed at two.
                    if (cnt_q == CW'(1)) begin
                        state_q   <= DivEnd;
                        cnt_q     <= '0;
                        result_q  <= '0;
                        ready_q   <= DivResultReady;
                        divzero_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DivOn: begin
                    part_q <= part_d;
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= DivEnd;
                        cnt_q     <= '0;
                        result_q  <= {cond_neg(part_d[2*WIDTH:WIDTH+1], rneg_q),
                                      cond_neg(part_d[WIDTH-1:0], qneg_q)};
                        ready_q   <= DivResultReady;
                        divzero_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(UNROLL);
                    end
                end
                DivEnd: begin
                    if (bus.start_i == DivStop) begin
                        state_q   <= DivFree;
                        result_q  <= '0;
                        ready_q   <= DivResultNotReady;
                        divzero_q <= 1'b0;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

    assign bus.result_o  = result_q;
    assign bus.ready_o   = ready_q;
    assign bus.divzero_o = divzero_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: UNROLL=1 and UNROLL=4 instances, vector table,
// randomized checks against an arithmetic model, and handshake corner sequences.
module tb_div_iter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) b1 ();
    div_iter_if #(.WIDTH(32)) b4 ();

    div_iter #(.WIDTH(32), .UNROLL(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    div_iter #(.WIDTH(32), .UNROLL(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    typedef struct {
        int          sel;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        bit          exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with C-style truncation.
    function automatic logic [64:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {1'b1, 64'd0};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input int sel, input logic [31:0] b);
        if (b == 0) return 2;
        return (sel == 0) ? 32 : 8;
    endfunction

    task automatic drive(input int sel, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic an);
        if (sel == 0) begin
            b1.signed_div_i = sgn; b1.opdata1_i = a; b1.opdata2_i = b;
            b1.start_i = st; b1.annul_i = an;
        end else begin
            b4.signed_div_i = sgn; b4.opdata1_i = a; b4.opdata2_i = b;
            b4.start_i = st; b4.annul_i = an;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? b1.ready_o : b4.ready_o;
    endfunction

    function automatic logic [63:0] res_of(input int sel);
        return (sel == 0) ? b1.result_o : b4.result_o;
    endfunction

    function automatic logic dz_of(input int sel);
        return (sel == 0) ? b1.divzero_o : b4.divzero_o;
    endfunction

    task automatic do_div(input int sel, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output logic dz, output int lat);
        @(negedge clk);
        drive(sel, sgn, a, b, 1'b1, 1'b0);
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!rdy(sel) && lat < 100);
        res = res_of(sel);
        dz  = dz_of(sel);
        @(negedge clk);
        drive(sel, sgn, $urandom, $urandom, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("drop_ready", {63'd0, rdy(sel)}, 64'd0);
        chk("drop_result", res_of(sel), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        logic        dz;
        int          lat;
        logic [64:0] r;
        bit          seen;

        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #12;
        chk("reset_ready", {62'd0, b1.ready_o, b4.ready_o}, 64'd0);
        chk("reset_result1", b1.result_o, 64'd0);
        chk("reset_divzero", {62'd0, b1.divzero_o, b4.divzero_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        vecs.push_back('{0, 1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 1'b0, 32});
        vecs.push_back('{0, 1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    1'b0, 32});
        vecs.push_back('{0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           1'b0, 32});
        vecs.push_back('{0, 1'b0, 32'd5,          32'd0,          64'd0,                           1'b1, 2});
        vecs.push_back('{1, 1'b1, 32'd5,          32'd0,          64'd0,                           1'b1, 2});
        vecs.push_back('{1, 1'b0, 32'hFFFFFFFF,   32'h10,         {32'hF, 32'h0FFFFFFF},           1'b0, 8});
        vecs.push_back('{0, 1'b0, 32'hFFFFFFFF,   32'h80000001,   {32'h7FFFFFFE, 32'd1},           1'b0, 32});
        vecs.push_back('{1, 1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           1'b0, 8});
        vecs.push_back('{1, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},          1'b0, 8});
        vecs.push_back('{1, 1'b0, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFF9C, 32'd0},           1'b0, 8});

        foreach (vecs[i]) begin
            do_div(vecs[i].sel, vecs[i].sgn, vecs[i].a, vecs[i].b, res, dz, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_divzero", i), {63'd0, dz}, {63'd0, vecs[i].exp_dz});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        for (int i = 0; i < 60; i++) begin
            int          sel;
            bit          sgn;
            logic [31:0] a, b;
            sel = i % 2;
            sgn = 1'($urandom);
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 15);
                1:       b = $urandom;
                2:       b = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: b = $urandom >> $urandom_range(0, 30);
            endcase
            r = ref_div(sgn, a, b);
            do_div(sel, sgn, a, b, res, dz, lat);
            chk($sformatf("rand%0d_result", i), res, r[63:0]);
            chk($sformatf("rand%0d_divzero", i), {63'd0, dz}, {63'd0, r[64]});
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_lat(sel, b)));
        end

        // Annul in cycle 10 of 100/7: nothing completes, fresh 9/3 works.
        @(negedge clk);
        drive(0, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (b1.ready_o) seen = 1'b1;
        end
        chk("annul_no_ready", {63'd0, seen}, 64'd0);
        do_div(0, 1'b0, 32'd9, 32'd3, res, dz, lat);
        chk("after_annul_result", res, {32'd0, 32'd3});
        chk("after_annul_latency", 64'(lat), 64'd32);

        // annul and start together in FREE: nothing starts.
        @(negedge clk);
        drive(1, 1'b0, 32'd50, 32'd5, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 32'd50, 32'd5, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (b4.ready_o) seen = 1'b1;
        end
        chk("annul_start_no_ready", {63'd0, seen}, 64'd0);

        // Hold start after ready on UNROLL=4: result stable, no restart.
        @(negedge clk);
        drive(1, 1'b0, 32'hFFFFFFFF, 32'h10, 1'b1, 1'b0);
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!b4.ready_o && lat < 100);
        chk("hold_latency", 64'(lat), 64'd8);
        @(negedge clk);
        drive(1, 1'b0, 32'd1, 32'd1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_ready", k), {63'd0, b4.ready_o}, 64'd1);
            chk($sformatf("hold%0d_result", k), b4.result_o, {32'hF, 32'h0FFFFFFF});
        end
        @(negedge clk);
        drive(1, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("hold_release_ready", {63'd0, b4.ready_o}, 64'd0);
        chk("hold_release_result", b4.result_o, 64'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        drive(1, 1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_ready", {63'd0, b4.ready_o}, 64'd0);
        chk("midreset_result", b4.result_o, 64'd0);
        drive(1, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (b4.ready_o) seen = 1'b1;
        end
        chk("midreset_no_ready", {63'd0, seen}, 64'd0);
        do_div(1, 1'b0, 32'd1000, 32'd3, res, dz, lat);
        chk("after_reset_result", res, {32'd1, 32'd333});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
